// File: rtl/mux_4_if.sv
// Bus bundle for the 4-to-1 data multiplexer.
// The master drives the four operand buses and the select, and receives the
// selected data plus its one-hot decode. The slave is the multiplexer itself.
// There is no valid/ready handshake on this bus. Every field is level-sampled:
// combinationally in the default build, or at posedge clk when the output
// register is enabled.
interface mux_4_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] in4;
  logic [1:0]       s;
  logic [WIDTH-1:0] out;
  logic [3:0]       sel_onehot;

  modport master (
    output in1, in2, in3, in4, s,
    input  out, sel_onehot
  );

  modport slave (
    input  in1, in2, in3, in4, s,
    output out, sel_onehot
  );
endinterface

// File: rtl/mux_4.sv
// 4-to-1 data multiplexer with a one-hot decode of the select.
//   s = 00 -> in1, 01 -> in2, 10 -> in3, 11 -> in4.
// Optional feature macro: MUX_4_REG_OUT_EN.
//   When it is undefined, the block is purely combinational and clk/rst are ignored.
//   When it is defined, out and sel_onehot are registered on posedge clk.
//   An asynchronous active-high rst forces out = 0 and sel_onehot = 4'b0001.
module mux_4 #(
  parameter int WIDTH = 16
) (
  input logic   clk,
  input logic   rst,
  mux_4_if.slave bus
);

  logic [WIDTH-1:0] mux_d;
  logic [3:0]       sel_d;

  // Select decode.
  // An unknown select falls into default, which propagates X in simulation.
  always_comb begin
    mux_d = {WIDTH{1'bx}};
    sel_d = 4'bxxxx;
    case (bus.s)
      2'b00: begin mux_d = bus.in1; sel_d = 4'b0001; end
      2'b01: begin mux_d = bus.in2; sel_d = 4'b0010; end
      2'b10: begin mux_d = bus.in3; sel_d = 4'b0100; end
      2'b11: begin mux_d = bus.in4; sel_d = 4'b1000; end
      default: begin
        mux_d = {WIDTH{1'bx}};
        sel_d = 4'bxxxx;
      end
    endcase
  end

`ifdef MUX_4_REG_OUT_EN
  logic [WIDTH-1:0] out_q;
  logic [3:0]       sel_q;

  // Output register.
  // Reset wins immediately and holds a safe in1 selection. Any capture that
  // was pending when reset arrived is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      sel_q <= 4'b0001;
    end else begin
      out_q <= mux_d;
      sel_q <= sel_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.sel_onehot = sel_q;
`else
  // In the combinational build, clk and rst have no function.
  logic unused_ok;
  assign unused_ok = ^{clk, rst};

  assign bus.out        = mux_d;
  assign bus.sel_onehot = sel_d;
`endif

endmodule

// File: tb/tb_mux_4.sv
// Directed bench for mux_4.
// It exercises the combinational build by default. It also covers the
// registered build when MUX_4_REG_OUT_EN is defined.
module tb_mux_4;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] in3;
    logic [W-1:0] in4;
    logic [1:0]   s;
    logic [W-1:0] exp_out;
    logic [3:0]   exp_sel;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  mux_4_if #(.WIDTH(W)) bus ();

  mux_4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached got=running want=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    bus.in1 = v.in1;
    bus.in2 = v.in2;
    bus.in3 = v.in3;
    bus.in4 = v.in4;
    bus.s   = v.s;
  endtask

  task automatic settle();
`ifdef MUX_4_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #3;
`endif
  endtask

  // ---------------- checkers ----------------
  task automatic check_out(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_sel(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[10];

  initial begin
    logic [W-1:0] exp_v;

    vecs[0] = '{16'hABCD, 16'h0123, 16'h0000, 16'h4567, 2'b00, 16'hABCD, 4'b0001};
    vecs[1] = '{16'hABCD, 16'h0123, 16'h0000, 16'h4567, 2'b01, 16'h0123, 4'b0010};
    vecs[2] = '{16'hABCD, 16'h0123, 16'h0000, 16'h4567, 2'b10, 16'h0000, 4'b0100};
    vecs[3] = '{16'hABCD, 16'h0123, 16'h0000, 16'h4567, 2'b11, 16'h4567, 4'b1000};
    vecs[4] = '{16'hABCD, 16'h0123, 16'h0000, 16'h4567, 2'b00, 16'hABCD, 4'b0001};
    vecs[5] = '{16'hFFFF, 16'h0123, 16'h0000, 16'h4567, 2'b01, 16'h0123, 4'b0010};
    vecs[6] = '{16'hFFFF, 16'h8888, 16'h0000, 16'h4567, 2'b01, 16'h8888, 4'b0010};
    vecs[7] = '{16'h1111, 16'h2222, 16'h5A5A, 16'hFFFF, 2'b10, 16'h5A5A, 4'b0100};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 2'b11, 16'h0001, 4'b1000};
    vecs[9] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 2'b01, 16'h0000, 4'b0010};

    // reset phase
    drive(vecs[3]);
    #3;
`ifdef MUX_4_REG_OUT_EN
    check_out("reset_out", bus.out, 16'h0000);
    check_sel("reset_sel", bus.sel_onehot, 4'b0001);
    @(posedge clk);
    #1;
    check_out("reset_hold_out", bus.out, 16'h0000);
`else
    check_out("rst_ignored_out", bus.out, 16'h4567);
    check_sel("rst_ignored_sel", bus.sel_onehot, 4'b1000);
`endif
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors through a scoreboard queue
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vecs[i].exp_out);
      drive(vecs[i]);
      settle();
      exp_v = exp_q.pop_front();
      check_out($sformatf("vec%0d_out", i), bus.out, exp_v);
      check_sel($sformatf("vec%0d_sel", i), bus.sel_onehot, vecs[i].exp_sel);
    end

`ifdef MUX_4_REG_OUT_EN
    // mid-run reset: immediate clear, held, then capture after release
    drive(vecs[1]);
    @(posedge clk);
    #2;
    check_out("pre_rst_out", bus.out, 16'h0123);
    rst = 1'b1;
    #1;
    check_out("async_rst_out", bus.out, 16'h0000);
    check_sel("async_rst_sel", bus.sel_onehot, 4'b0001);
    bus.s = 2'b11;
    @(posedge clk);
    #1;
    check_out("rst_held_out", bus.out, 16'h0000);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_out("rst_release_out", bus.out, 16'h4567);
    check_sel("rst_release_sel", bus.sel_onehot, 4'b1000);

    // select toggle between edges: output waits for the edge
    bus.s = 2'b00;
    @(posedge clk);
    #1;
    check_out("tog_before_out", bus.out, 16'hABCD);
    #1;
    bus.s = 2'b01;
    #2;
    check_out("tog_mid_out", bus.out, 16'hABCD);
    check_sel("tog_mid_sel", bus.sel_onehot, 4'b0001);
    @(posedge clk);
    #1;
    check_out("tog_after_out", bus.out, 16'h0123);
    check_sel("tog_after_sel", bus.sel_onehot, 4'b0010);
`else
    // zero latency: a non-selected input change is ignored, a selected one is followed
    drive(vecs[1]);
    #3;
    bus.in3 = 16'h7777;
    #3;
    check_out("nonsel_change_out", bus.out, 16'h0123);
    bus.in2 = 16'hBEEF;
    #3;
    check_out("sel_change_out", bus.out, 16'hBEEF);
    bus.s = 2'b10;
    #3;
    check_out("s_change_out", bus.out, 16'h7777);
    check_sel("s_change_sel", bus.sel_onehot, 4'b0100);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
